// File: rtl/ps2_kbd_pkg.sv
// Shared types and Set-2 scancode tables for the PS/2 to Spectrum key-matrix bridge.
package ps2_kbd_pkg;

    localparam int unsigned NumKeys  = 50;
    localparam int unsigned NumCells = 40;

    localparam logic [7:0] CodeExt  = 8'hE0;
    localparam logic [7:0] CodeRel  = 8'hF0;
    localparam logic [7:0] CodeBat  = 8'hAA;
    localparam logic [7:0] CodeOvf0 = 8'h00;
    localparam logic [7:0] CodeOvf1 = 8'hFF;

    // Keys 0..39 own matrix cell row*5+col; the rest alias or combine existing cells.
    typedef enum logic [5:0] {
        KeyLShift, KeyZ,     KeyX,     KeyC,     KeyV,
        KeyA,      KeyS,     KeyD,     KeyF,     KeyG,
        KeyQ,      KeyW,     KeyE,     KeyR,     KeyT,
        Key1,      Key2,     Key3,     Key4,     Key5,
        Key0,      Key9,     Key8,     Key7,     Key6,
        KeyP,      KeyO,     KeyI,     KeyU,     KeyY,
        KeyEnter,  KeyL,     KeyK,     KeyJ,     KeyH,
        KeySpace,  KeyLCtrl, KeyM,     KeyN,     KeyB,
        KeyRShift, KeyRCtrl, KeyBksp,  KeyLeft,  KeyDown,
        KeyUp,     KeyRight, KeyLAlt,  KeyRAlt,  KeyDel
    } key_e;

    typedef struct packed {
        logic valid;
        key_e key;
    } scan_t;

    typedef struct packed {
        logic       v0;
        logic [5:0] c0;
        logic       v1;
        logic [5:0] c1;
    } key_pos_t;

    function automatic scan_t scan_lookup(input logic ext, input logic [7:0] code);
        scan_t s;
        key_e  key;
        logic  hit;
        key = KeyLShift;
        hit = 1'b1;
        if (!ext) begin
            case (code)
                8'h12: key = KeyLShift;  8'h1A: key = KeyZ;      8'h22: key = KeyX;
                8'h21: key = KeyC;       8'h2A: key = KeyV;      8'h1C: key = KeyA;
                8'h1B: key = KeyS;       8'h23: key = KeyD;      8'h2B: key = KeyF;
                8'h34: key = KeyG;       8'h15: key = KeyQ;      8'h1D: key = KeyW;
                8'h24: key = KeyE;       8'h2D: key = KeyR;      8'h2C: key = KeyT;
                8'h16: key = Key1;       8'h1E: key = Key2;      8'h26: key = Key3;
                8'h25: key = Key4;       8'h2E: key = Key5;      8'h45: key = Key0;
                8'h46: key = Key9;       8'h3E: key = Key8;      8'h3D: key = Key7;
                8'h36: key = Key6;       8'h4D: key = KeyP;      8'h44: key = KeyO;
                8'h43: key = KeyI;       8'h3C: key = KeyU;      8'h35: key = KeyY;
                8'h5A: key = KeyEnter;   8'h4B: key = KeyL;      8'h42: key = KeyK;
                8'h3B: key = KeyJ;       8'h33: key = KeyH;      8'h29: key = KeySpace;
                8'h14: key = KeyLCtrl;   8'h3A: key = KeyM;      8'h31: key = KeyN;
                8'h32: key = KeyB;       8'h59: key = KeyRShift; 8'h66: key = KeyBksp;
                8'h11: key = KeyLAlt;
                default: hit = 1'b0;
            endcase
        end else begin
            case (code)
                8'h14: key = KeyRCtrl;   8'h11: key = KeyRAlt;   8'h71: key = KeyDel;
                8'h6B: key = KeyLeft;    8'h72: key = KeyDown;   8'h75: key = KeyUp;
                8'h74: key = KeyRight;
                default: hit = 1'b0;
            endcase
        end
        s.valid = hit;
        s.key   = key;
        return s;
    endfunction

    function automatic key_pos_t key_pos(input key_e key);
        key_pos_t p;
        p.v0 = 1'b1;
        p.c0 = 6'(key);
        p.v1 = 1'b0;
        p.c1 = 6'd0;
        case (key)
            KeyRShift: p.c0 = KeyLShift;
            KeyRCtrl:  p.c0 = KeyLCtrl;
            KeyBksp:   begin p.c0 = KeyLShift; p.v1 = 1'b1; p.c1 = Key0; end
            KeyLeft:   begin p.c0 = KeyLShift; p.v1 = 1'b1; p.c1 = Key5; end
            KeyDown:   begin p.c0 = KeyLShift; p.v1 = 1'b1; p.c1 = Key6; end
            KeyUp:     begin p.c0 = KeyLShift; p.v1 = 1'b1; p.c1 = Key7; end
            KeyRight:  begin p.c0 = KeyLShift; p.v1 = 1'b1; p.c1 = Key8; end
            KeyLAlt, KeyRAlt, KeyDel: p.v0 = 1'b0;
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronisers, clock glitch filter, frame FSM and idle timeout.
module ps2_rx
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FilterLen     = 8,
    parameter int unsigned TimeoutCycles = 14000
) (
    input  logic       clk14,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned FiltW = $clog2(FilterLen + 1);
    localparam int unsigned TmoW  = $clog2(TimeoutCycles + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            filt_q, filt_d, strobe_q;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic [1:0]      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            valid_q, valid_d, err_q, err_d;
    logic            clk_s, dat_s;

    assign clk_s        = clk_sync_q[1];
    assign dat_s        = dat_sync_q[1];
    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = err_q;

    // The filtered level only follows after FilterLen consecutive disagreeing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FiltW'(FilterLen - 1)) filt_d = clk_s;
            else filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        tmo_d     = (state_q == StIdle || strobe_q) ? '0 : tmo_q + 1'b1;
        if (state_q != StIdle && tmo_q == TmoW'(TimeoutCycles)) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else if (strobe_q) begin
            case (state_q)
                StIdle: begin
                    if (!dat_s) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_d   = dat_s;
                    state_d = StStop;
                end
                default: begin
                    state_d = StIdle;
                    if (dat_s && ^{shift_q, par_q}) valid_d = 1'b1;
                    else err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            strobe_q   <= 1'b0;
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            strobe_q   <= filt_q & ~filt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 keyboard to emulated 8x5 Spectrum key matrix, read through the ULA port #FE path.
module ps2_keyboard_matrix
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 14000
) (
    input  logic       clk14,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] addr_hi,
    output logic [4:0] kd,
    output logic       reset_req,
    output logic       frame_err
);

    logic [7:0]          rx_byte;
    logic                rx_valid;
    logic                ext_q, ext_d, rel_q, rel_d;
    logic [NumKeys-1:0]  keys_q, keys_d;
    logic                reset_req_q, reset_req_d;
    logic [NumCells-1:0] cells;
    scan_t               scan;

    ps2_rx #(
        .FilterLen    (FILTER_LEN),
        .TimeoutCycles(TIMEOUT_CYCLES)
    ) u_rx (
        .clk14       (clk14),
        .rst_n       (rst_n),
        .ps2_clk_i   (ps2_clk),
        .ps2_dat_i   (ps2_dat),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (frame_err)
    );

    assign scan = scan_lookup(ext_q, rx_byte);

    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        keys_d = keys_q;
        if (rx_valid) begin
            if (rx_byte == CodeExt) begin
                ext_d = 1'b1;
            end else if (rx_byte == CodeRel) begin
                rel_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                rel_d = 1'b0;
                if (rx_byte inside {CodeBat, CodeOvf0, CodeOvf1}) keys_d = '0;
                else if (scan.valid) keys_d[scan.key] = ~rel_q;
            end
        end
    end

    assign reset_req_d = (keys_q[KeyLCtrl] | keys_q[KeyRCtrl]) &
                         (keys_q[KeyLAlt] | keys_q[KeyRAlt]) & keys_q[KeyDel];
    assign reset_req   = reset_req_q;

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            keys_q      <= '0;
            reset_req_q <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            keys_q      <= keys_d;
            reset_req_q <= reset_req_d;
        end
    end

    // Each cell is the OR of every key flag that drives it, so aliases never cancel each other.
    always_comb begin
        key_pos_t p;
        p     = '0;
        cells = '0;
        for (int k = 0; k < NumKeys; k++) begin
            p = key_pos(key_e'(k));
            if (keys_q[k] && p.v0) cells[p.c0] = 1'b1;
            if (keys_q[k] && p.v1) cells[p.c1] = 1'b1;
        end
    end

    always_comb begin
        kd = '1;
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (!addr_hi[r] && cells[r*5+c]) kd[c] = 1'b0;
            end
        end
    end

endmodule
